i2c_slave_core: RTL and testbench

I2C target (slave) endpoint that attaches to an open-drain SCL/SDA bus and bridges it to byte-wide streaming ports on the system clock. It supports master writes, delivered as one-cycle-valid bytes on `data_o`, and master reads, which pull bytes from a valid/ready source on `data_i`. It uses a 7-bit address, runs at standard I2C bit rates, and does no clock stretching.

---
 rtl/i2c_slave_if.sv | 24 ++
 rtl/i2c_slave_core.sv | 185 ++++++++++++++++++
 tb/tb_i2c_slave_core.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_if.sv
// Bus-side and streaming-side signals of the I2C target endpoint.
// The master modport is the view of whatever sits across from the target.
`timescale 1ns/1ps
interface i2c_slave_if;
  logic       scl_i;
  logic       sda_i;
  logic       scl_o;
  logic       sda_o;
  logic [7:0] data_i;
  logic       data_i_valid;
  logic       data_i_ready;
  logic [7:0] data_o;
  logic       data_o_valid;

  modport slave (
    input  scl_i, sda_i, data_i, data_i_valid,
    output scl_o, sda_o, data_i_ready, data_o, data_o_valid
  );

  modport master (
    output scl_i, sda_i, data_i, data_i_valid,
    input  scl_o, sda_o, data_i_ready, data_o, data_o_valid
  );
endinterface

// File: rtl/i2c_slave_core.sv
// I2C target endpoint: 7-bit address, master writes stream out on data_o,
// master reads pull bytes from a valid/ready source. No clock stretching.
`timescale 1ns/1ps
module i2c_slave_core #(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h21
) (
  input  logic clk,
  input  logic rst,
  i2c_slave_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d;
  logic       sda_prev_q, sda_prev_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       rw_q, rw_d;
  logic       sda_o_q, sda_o_d;
  logic [7:0] data_o_q, data_o_d;
  logic       data_o_valid_q, data_o_valid_d;
  logic       data_i_ready_q, data_i_ready_d;

  logic       scl, sda;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] load_byte;

  assign scl       = scl_sync_q[1];
  assign sda       = sda_sync_q[1];
  assign scl_rise  = scl & ~scl_prev_q;
  assign scl_fall  = ~scl & scl_prev_q;
  assign start_det = scl & scl_prev_q & ~sda & sda_prev_q;
  assign stop_det  = scl & scl_prev_q & sda & ~sda_prev_q;
  // An empty source reads back as an idle (released) bus byte.
  assign load_byte = bus.data_i_valid ? bus.data_i : 8'hFF;

  assign bus.scl_o        = 1'b1;
  assign bus.sda_o        = sda_o_q;
  assign bus.data_o       = data_o_q;
  assign bus.data_o_valid = data_o_valid_q;
  assign bus.data_i_ready = data_i_ready_q;

  always_comb begin
    scl_sync_d     = {scl_sync_q[0], bus.scl_i};
    sda_sync_d     = {sda_sync_q[0], bus.sda_i};
    scl_prev_d     = scl;
    sda_prev_d     = sda;
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    rx_d           = rx_q;
    tx_d           = tx_q;
    rw_d           = rw_q;
    sda_o_d        = sda_o_q;
    data_o_d       = data_o_q;
    data_o_valid_d = 1'b0;
    data_i_ready_d = 1'b0;

    // Bus conditions win over any SCL edge seen in the same cycle.
    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_o_d   = 1'b1;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      sda_o_d   = 1'b1;
    end else begin
      unique case (state_q)
        ADDR: begin
          if (scl_rise) begin
            rx_d      = {rx_q[6:0], sda};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (rx_q[7:1] == SLAVE_ADDRESS) begin
              sda_o_d = 1'b0;
              rw_d    = rx_q[0];
              state_d = ADDR_ACK;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              tx_d           = load_byte;
              sda_o_d        = load_byte[7];
              data_i_ready_d = bus.data_i_valid;
              state_d        = RD_DATA;
            end else begin
              sda_o_d = 1'b1;
              state_d = WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            rx_d      = {rx_q[6:0], sda};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              data_o_d       = {rx_q[6:0], sda};
              data_o_valid_d = 1'b1;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_o_d = 1'b0;
            state_d = WR_ACK;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_o_d   = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_o_d = 1'b1;
              state_d = RD_ACK;
            end else begin
              tx_d    = {tx_q[6:0], 1'b1};
              sda_o_d = tx_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise && sda) begin
            state_d = WAIT_STOP;
          end else if (scl_fall) begin
            tx_d           = load_byte;
            sda_o_d        = load_byte[7];
            data_i_ready_d = bus.data_i_valid;
            bit_cnt_d      = 4'd0;
            state_d        = RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  // Synchronizers reset to the idle-bus level so release does not fake an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q     <= 2'b11;
      sda_sync_q     <= 2'b11;
      scl_prev_q     <= 1'b1;
      sda_prev_q     <= 1'b1;
      state_q        <= IDLE;
      bit_cnt_q      <= 4'd0;
      rx_q           <= 8'd0;
      tx_q           <= 8'd0;
      rw_q           <= 1'b0;
      sda_o_q        <= 1'b1;
      data_o_q       <= 8'd0;
      data_o_valid_q <= 1'b0;
      data_i_ready_q <= 1'b0;
    end else begin
      scl_sync_q     <= scl_sync_d;
      sda_sync_q     <= sda_sync_d;
      scl_prev_q     <= scl_prev_d;
      sda_prev_q     <= sda_prev_d;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_q           <= rx_d;
      tx_q           <= tx_d;
      rw_q           <= rw_d;
      sda_o_q        <= sda_o_d;
      data_o_q       <= data_o_d;
      data_o_valid_q <= data_o_valid_d;
      data_i_ready_q <= data_i_ready_d;
    end
  end

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench for i2c_slave_core: bit-banged I2C master, scoreboard on data_o,
// queue-backed byte source on data_i.
`timescale 1ns/1ps
module tb_i2c_slave_core;

  typedef struct {
    logic [7:0]      addr;
    int              n;
    logic [3:0][7:0] d;
    logic            exp_ack;
  } wr_vec_t;

  logic clk;
  logic rst;
  logic scl_m;
  logic sda_m;

  int tests_run = 0;
  int fail_cnt  = 0;
  int rdy_cnt   = 0;
  int nack_viol = 0;
  logic watch_nack = 1'b0;
  logic valid_prev = 1'b0;
  logic rdy_prev   = 1'b0;
  logic [7:0] exp_rx[$];
  logic [7:0] src_q[$];
  logic [7:0] e;

  i2c_slave_if bif();

  i2c_slave_core #(.SLAVE_ADDRESS(7'h21)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  assign bif.scl_i = scl_m & bif.scl_o;
  assign bif.sda_i = sda_m & bif.sda_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard for received bytes, source queue for transmitted bytes.
  always @(negedge clk) begin
    if (bif.data_o_valid) begin
      check("dov_width", {31'd0, valid_prev}, 32'd0);
      if (exp_rx.size() == 0) begin
        tests_run++;
        fail_cnt++;
        $display("FAIL unexpected_rx: got %02h required no byte", bif.data_o);
      end else begin
        e = exp_rx.pop_front();
        check("rx_byte", {24'd0, bif.data_o}, {24'd0, e});
      end
      $display("[TB] rx byte %02h", bif.data_o);
    end
    valid_prev = bif.data_o_valid;
    if (bif.data_i_ready) begin
      check("rdy_width", {31'd0, rdy_prev}, 32'd0);
      rdy_cnt++;
      if (src_q.size() > 0) void'(src_q.pop_front());
    end
    rdy_prev = bif.data_i_ready;
    if (watch_nack && bif.sda_o !== 1'b1) nack_viol++;
    bif.data_i       = (src_q.size() > 0) ? src_q[0] : 8'h00;
    bif.data_i_valid = (src_q.size() > 0);
  end

  task automatic i2c_start();
    sda_m = 1'b1; #250;
    scl_m = 1'b1; #250;
    sda_m = 1'b0; #250;
    scl_m = 1'b0; #250;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #250;
    scl_m = 1'b1; #250;
    sda_m = 1'b1; #500;
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    sda_m = b;    #250;
    scl_m = 1'b1; #250;
    s = sda_m & bif.sda_o;
    #250;
    scl_m = 1'b0; #250;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      b[i] = s;
    end
    bit_xfer(mack, s);
  endtask

  task automatic drain(input string name);
    repeat (50) @(negedge clk);
    check(name, exp_rx.size(), 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_vec_t    vecs[3];
    logic       ack;
    logic [7:0] b;

    vecs[0].addr = 8'h42; vecs[0].n = 1; vecs[0].exp_ack = 1'b1;
    vecs[0].d    = {8'h00, 8'h00, 8'h00, 8'h5A};
    vecs[1].addr = 8'h42; vecs[1].n = 4; vecs[1].exp_ack = 1'b1;
    vecs[1].d    = {8'h1A, 8'h7E, 8'h33, 8'h5A};
    vecs[2].addr = 8'h44; vecs[2].n = 1; vecs[2].exp_ack = 1'b0;
    vecs[2].d    = {8'h00, 8'h00, 8'h00, 8'h5A};

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_sda_o", {31'd0, bif.sda_o}, 32'd1);
    check("rst_scl_o", {31'd0, bif.scl_o}, 32'd1);
    check("rst_data_o", {24'd0, bif.data_o}, 32'd0);
    check("rst_data_o_valid", {31'd0, bif.data_o_valid}, 32'd0);
    check("rst_data_i_ready", {31'd0, bif.data_i_ready}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    for (int v = 0; v < 3; v++) begin
      $display("[TB] write addr=%02h bytes=%0d", vecs[v].addr, vecs[v].n);
      nack_viol  = 0;
      watch_nack = !vecs[v].exp_ack;
      i2c_start();
      write_byte(vecs[v].addr, ack);
      check("addr_ack", {31'd0, ack}, {31'd0, !vecs[v].exp_ack});
      for (int j = 0; j < vecs[v].n; j++) begin
        if (vecs[v].exp_ack) exp_rx.push_back(vecs[v].d[j]);
        write_byte(vecs[v].d[j], ack);
        check("data_ack", {31'd0, ack}, {31'd0, !vecs[v].exp_ack});
      end
      i2c_stop();
      watch_nack = 1'b0;
      drain("rx_drain");
      if (!vecs[v].exp_ack) check("nack_sda_held", nack_viol, 0);
    end

    $display("[TB] read 2 bytes addr=43");
    rdy_cnt = 0;
    src_q.push_back(8'h81);
    src_q.push_back(8'h5A);
    i2c_start();
    write_byte(8'h43, ack);
    check("rd_addr_ack", {31'd0, ack}, 32'd0);
    read_byte(1'b0, b);
    check("rd_byte0", {24'd0, b}, 32'h81);
    read_byte(1'b1, b);
    check("rd_byte1", {24'd0, b}, 32'h5A);
    check("rd_sda_released", {31'd0, bif.sda_o}, 32'd1);
    i2c_stop();
    check("rd_ready_pulses", rdy_cnt, 2);

    $display("[TB] read 1 byte with empty source");
    rdy_cnt = 0;
    i2c_start();
    write_byte(8'h43, ack);
    check("rd_empty_addr_ack", {31'd0, ack}, 32'd0);
    read_byte(1'b1, b);
    check("rd_empty_byte", {24'd0, b}, 32'hFF);
    i2c_stop();
    check("rd_empty_no_ready", rdy_cnt, 0);

    $display("[TB] write 5A then repeated start read");
    rdy_cnt = 0;
    i2c_start();
    write_byte(8'h42, ack);
    check("rs_wr_addr_ack", {31'd0, ack}, 32'd0);
    exp_rx.push_back(8'h5A);
    write_byte(8'h5A, ack);
    check("rs_wr_data_ack", {31'd0, ack}, 32'd0);
    src_q.push_back(8'h81);
    i2c_start();
    write_byte(8'h43, ack);
    check("rs_rd_addr_ack", {31'd0, ack}, 32'd0);
    read_byte(1'b1, b);
    check("rs_rd_byte", {24'd0, b}, 32'h81);
    i2c_stop();
    drain("rs_rx_drain");
    check("rs_ready_pulses", rdy_cnt, 1);

    $display("[TB] reset during read then write C4");
    src_q.push_back(8'h00);
    i2c_start();
    write_byte(8'h43, ack);
    check("rr_addr_ack", {31'd0, ack}, 32'd0);
    check("rr_drive_low", {31'd0, bif.sda_o}, 32'd0);
    #100;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rr_async_release", {31'd0, bif.sda_o}, 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    sda_m = 1'b1; #250;
    scl_m = 1'b1; #500;
    i2c_start();
    write_byte(8'h42, ack);
    check("rr_wr_addr_ack", {31'd0, ack}, 32'd0);
    exp_rx.push_back(8'hC4);
    write_byte(8'hC4, ack);
    check("rr_wr_data_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    drain("rr_rx_drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
